// File: rtl/d_resp_arbiter.sv
// d_resp_arbiter
// Three-requester round-robin arbiter that feeds one holding entry toward the
// downstream D-channel. The entry is replaced in the same edge it drains, so a
// continuously ready sink sees one response per cycle with no bubbles.
// The input readys are combinational because a requester's response is
// accepted in the same cycle that it is granted.
// Optional feature macro: D_ARB_GRANT_CNT_EN adds saturating 16-bit per-requester
// grant counters on io_grant_count_0..2.
module d_resp_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_0_valid,
    output logic        io_in_0_ready,
    input  logic [2:0]  io_in_0_bits_opcode,
    input  logic [1:0]  io_in_0_bits_size,
    input  logic [10:0] io_in_0_bits_source,
    input  logic [63:0] io_in_0_bits_data,
    input  logic        io_in_1_valid,
    output logic        io_in_1_ready,
    input  logic [2:0]  io_in_1_bits_opcode,
    input  logic [1:0]  io_in_1_bits_size,
    input  logic [10:0] io_in_1_bits_source,
    input  logic [63:0] io_in_1_bits_data,
    input  logic        io_in_2_valid,
    output logic        io_in_2_ready,
    input  logic [2:0]  io_in_2_bits_opcode,
    input  logic [1:0]  io_in_2_bits_size,
    input  logic [10:0] io_in_2_bits_source,
    input  logic [63:0] io_in_2_bits_data,
    output logic        io_deq_valid,
    input  logic        io_deq_ready,
    output logic [2:0]  io_deq_bits_opcode,
    output logic [1:0]  io_deq_bits_param,
    output logic [1:0]  io_deq_bits_size,
    output logic [10:0] io_deq_bits_source,
    output logic        io_deq_bits_sink,
    output logic        io_deq_bits_denied,
    output logic [63:0] io_deq_bits_data,
`ifdef D_ARB_GRANT_CNT_EN
    output logic [15:0] io_grant_count_0,
    output logic [15:0] io_grant_count_1,
    output logic [15:0] io_grant_count_2,
`endif
    output logic        io_deq_bits_corrupt
);

    // Holding entry and arbitration state
    logic        r_full;
    logic [1:0]  r_last_grant;
    logic [2:0]  r_opcode;
    logic [1:0]  r_size;
    logic [10:0] r_source;
    logic [63:0] r_data;

    logic        w_free;
    logic [2:0]  w_valid;
    logic        w_grant_any;
    logic [1:0]  w_grant_idx;
    logic [2:0]  w_sel_opcode;
    logic [1:0]  w_sel_size;
    logic [10:0] w_sel_source;
    logic [63:0] w_sel_data;

    assign w_free  = ~r_full | io_deq_ready;
    assign w_valid = {io_in_2_valid, io_in_1_valid, io_in_0_valid};

    // Round-robin pick: search starts just after the last granted requester;
    // no grant while the entry cannot take a new response or reset is high
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = 2'd0;
        if (w_free && !reset) begin
            case (r_last_grant)
                2'd0: begin
                    if (w_valid[1])      begin w_grant_any = 1'b1; w_grant_idx = 2'd1; end
                    else if (w_valid[2]) begin w_grant_any = 1'b1; w_grant_idx = 2'd2; end
                    else if (w_valid[0]) begin w_grant_any = 1'b1; w_grant_idx = 2'd0; end
                    else                 begin w_grant_any = 1'b0; w_grant_idx = 2'd0; end
                end
                2'd1: begin
                    if (w_valid[2])      begin w_grant_any = 1'b1; w_grant_idx = 2'd2; end
                    else if (w_valid[0]) begin w_grant_any = 1'b1; w_grant_idx = 2'd0; end
                    else if (w_valid[1]) begin w_grant_any = 1'b1; w_grant_idx = 2'd1; end
                    else                 begin w_grant_any = 1'b0; w_grant_idx = 2'd0; end
                end
                default: begin
                    if (w_valid[0])      begin w_grant_any = 1'b1; w_grant_idx = 2'd0; end
                    else if (w_valid[1]) begin w_grant_any = 1'b1; w_grant_idx = 2'd1; end
                    else if (w_valid[2]) begin w_grant_any = 1'b1; w_grant_idx = 2'd2; end
                    else                 begin w_grant_any = 1'b0; w_grant_idx = 2'd0; end
                end
            endcase
        end else begin
            w_grant_any = 1'b0;
            w_grant_idx = 2'd0;
        end
    end

    // One-hot ready toward the granted requester only
    always_comb begin
        io_in_0_ready = 1'b0;
        io_in_1_ready = 1'b0;
        io_in_2_ready = 1'b0;
        if (w_grant_any) begin
            case (w_grant_idx)
                2'd0:    io_in_0_ready = 1'b1;
                2'd1:    io_in_1_ready = 1'b1;
                2'd2:    io_in_2_ready = 1'b1;
                default: io_in_0_ready = 1'b0;
            endcase
        end else begin
            io_in_0_ready = 1'b0;
        end
    end

    // Field mux selecting the granted requester's response
    always_comb begin
        w_sel_opcode = io_in_0_bits_opcode;
        w_sel_size   = io_in_0_bits_size;
        w_sel_source = io_in_0_bits_source;
        w_sel_data   = io_in_0_bits_data;
        case (w_grant_idx)
            2'd1: begin
                w_sel_opcode = io_in_1_bits_opcode;
                w_sel_size   = io_in_1_bits_size;
                w_sel_source = io_in_1_bits_source;
                w_sel_data   = io_in_1_bits_data;
            end
            2'd2: begin
                w_sel_opcode = io_in_2_bits_opcode;
                w_sel_size   = io_in_2_bits_size;
                w_sel_source = io_in_2_bits_source;
                w_sel_data   = io_in_2_bits_data;
            end
            default: begin
                w_sel_opcode = io_in_0_bits_opcode;
                w_sel_size   = io_in_0_bits_size;
                w_sel_source = io_in_0_bits_source;
                w_sel_data   = io_in_0_bits_data;
            end
        endcase
    end

    // Occupancy and round-robin pointer; a grant wins over a drain so the
    // entry is refilled in the same edge without a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            r_full       <= 1'b0;
            r_last_grant <= 2'd2;
        end else if (w_grant_any) begin
            r_full       <= 1'b1;
            r_last_grant <= w_grant_idx;
        end else if (io_deq_ready && r_full) begin
            r_full       <= 1'b0;
        end
    end

    // Entry payload; deliberately not reset since r_full qualifies it
    always_ff @(posedge clock) begin
        if (w_grant_any) begin
            r_opcode <= w_sel_opcode;
            r_size   <= w_sel_size;
            r_source <= w_sel_source;
            r_data   <= w_sel_data;
        end
    end

`ifdef D_ARB_GRANT_CNT_EN
    logic [15:0] r_grant_cnt [3];

    // Saturating per-requester grant counters
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                r_grant_cnt[k] <= 16'd0;
            end else if (w_grant_any && (w_grant_idx == 2'(k)) && (r_grant_cnt[k] != 16'hFFFF)) begin
                r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
            end
        end
    end

    assign io_grant_count_0 = r_grant_cnt[0];
    assign io_grant_count_1 = r_grant_cnt[1];
    assign io_grant_count_2 = r_grant_cnt[2];
`endif

    assign io_deq_valid        = r_full;
    assign io_deq_bits_opcode  = r_opcode;
    assign io_deq_bits_param   = 2'd0;
    assign io_deq_bits_size    = r_size;
    assign io_deq_bits_source  = r_source;
    assign io_deq_bits_sink    = 1'b0;
    assign io_deq_bits_denied  = 1'b0;
    assign io_deq_bits_data    = r_data;
    assign io_deq_bits_corrupt = 1'b0;

endmodule

// File: tb/tb_d_resp_arbiter.sv
// Testbench for d_resp_arbiter: directed scenarios plus a randomized run
// checked against a queue-free behavioural model of the arbitration rules.
module tb_d_resp_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  v;
    logic [2:0]  op  [3];
    logic [1:0]  sz  [3];
    logic [10:0] src [3];
    logic [63:0] dat [3];
    logic        deq_ready;

    logic        rdy0, rdy1, rdy2;
    logic        deq_valid;
    logic [2:0]  deq_opcode;
    logic [1:0]  deq_param;
    logic [1:0]  deq_size;
    logic [10:0] deq_source;
    logic        deq_sink, deq_denied, deq_corrupt;
    logic [63:0] deq_data;
`ifdef D_ARB_GRANT_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    wire [2:0] rdy = {rdy2, rdy1, rdy0};

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    bit          m_full;
    int          m_last;
    logic [2:0]  m_op;
    logic [1:0]  m_sz;
    logic [10:0] m_src;
    logic [63:0] m_dat;

    always #5 clock = ~clock;

    d_resp_arbiter dut (
        .clock(clock), .reset(reset),
        .io_in_0_valid(v[0]), .io_in_0_ready(rdy0),
        .io_in_0_bits_opcode(op[0]), .io_in_0_bits_size(sz[0]),
        .io_in_0_bits_source(src[0]), .io_in_0_bits_data(dat[0]),
        .io_in_1_valid(v[1]), .io_in_1_ready(rdy1),
        .io_in_1_bits_opcode(op[1]), .io_in_1_bits_size(sz[1]),
        .io_in_1_bits_source(src[1]), .io_in_1_bits_data(dat[1]),
        .io_in_2_valid(v[2]), .io_in_2_ready(rdy2),
        .io_in_2_bits_opcode(op[2]), .io_in_2_bits_size(sz[2]),
        .io_in_2_bits_source(src[2]), .io_in_2_bits_data(dat[2]),
        .io_deq_valid(deq_valid), .io_deq_ready(deq_ready),
        .io_deq_bits_opcode(deq_opcode), .io_deq_bits_param(deq_param),
        .io_deq_bits_size(deq_size), .io_deq_bits_source(deq_source),
        .io_deq_bits_sink(deq_sink), .io_deq_bits_denied(deq_denied),
        .io_deq_bits_data(deq_data),
`ifdef D_ARB_GRANT_CNT_EN
        .io_grant_count_0(cnt0), .io_grant_count_1(cnt1), .io_grant_count_2(cnt2),
`endif
        .io_deq_bits_corrupt(deq_corrupt)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Expected grant from the rules: free = empty or draining; scan starting
    // after the last grant, modulo 3. Returns -1 for no grant.
    function automatic int exp_grant(input logic [2:0] vv, input logic dr);
        if (m_full && !dr) return -1;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (vv[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [2:0] vv, input logic dr);
        int g;
        g = exp_grant(vv, dr);
        if (g >= 0) begin
            m_full = 1'b1;
            m_last = g;
            m_op = op[g]; m_sz = sz[g]; m_src = src[g]; m_dat = dat[g];
        end else if (dr && m_full) begin
            m_full = 1'b0;
        end
    endtask

    task automatic apply_reset;
        reset = 1'b1; v = 3'b000; deq_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        m_full = 1'b0; m_last = 2;
    endtask

    task automatic test_reset;
        reset = 1'b1; v = 3'b111; deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op[i] = 3'd1; sz[i] = 2'd2; src[i] = 11'(i); dat[i] = 64'(i);
        end
        tick;
        #1;
        n_cmp++;
        if (rdy !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", rdy); end
        n_cmp++;
        if (deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
`ifdef D_ARB_GRANT_CNT_EN
        n_cmp++;
        if ({cnt0, cnt1, cnt2} !== 48'd0) begin n_err++; $display("FAIL reset_counts: got %h %h %h want 0", cnt0, cnt1, cnt2); end
`endif
        reset = 1'b0; v = 3'b000;
        m_full = 1'b0; m_last = 2;
        tick;
    endtask

    task automatic test_single;
        apply_reset;
        v = 3'b010; op[1] = 3'd1; sz[1] = 2'd3; src[1] = 11'h005; dat[1] = 64'hA5;
        deq_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want 010", rdy); end
        tick;
        v = 3'b000;
        #1;
        n_cmp++;
        if (deq_valid !== 1'b1) begin n_err++; $display("FAIL single_deq_valid: got %b want 1", deq_valid); end
        n_cmp++;
        if ({deq_opcode, deq_size, deq_source, deq_data} !== {3'd1, 2'd3, 11'h005, 64'hA5}) begin
            n_err++;
            $display("FAIL single_fields: got op=%0d sz=%0d src=%h data=%h want op=1 sz=3 src=005 data=a5",
                     deq_opcode, deq_size, deq_source, deq_data);
        end
        n_cmp++;
        if ({deq_param, deq_sink, deq_denied, deq_corrupt} !== 5'd0) begin
            n_err++;
            $display("FAIL single_const: got param=%0d sink=%b denied=%b corrupt=%b want 0",
                     deq_param, deq_sink, deq_denied, deq_corrupt);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
        apply_reset;
        for (int i = 0; i < 3; i++) begin
            src[i] = 11'(16 + i); dat[i] = 64'(100 + i);
        end
        v = 3'b111; deq_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if (rdy !== (3'b001 << exp_seq[k])) begin
                n_err++; $display("FAIL b2b_grant%0d: got %b want requester %0d", k, rdy, exp_seq[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (deq_valid !== 1'b1 || deq_source !== 11'(16 + exp_seq[k-1])) begin
                    n_err++;
                    $display("FAIL b2b_deq%0d: got valid=%b src=%h want valid=1 src=%h",
                             k, deq_valid, deq_source, 11'(16 + exp_seq[k-1]));
                end
            end
            tick;
        end
        v = 3'b000;
        #1;
        n_cmp++;
        if (deq_valid !== 1'b1 || deq_source !== 11'd18) begin
            n_err++; $display("FAIL b2b_last: got valid=%b src=%h want valid=1 src=012", deq_valid, deq_source);
        end
        tick;
    endtask

    task automatic test_stall;
        apply_reset;
        v = 3'b001; src[0] = 11'h123; dat[0] = 64'hDEAD_BEEF_0000_0001; deq_ready = 1'b1;
        tick;
        src[0] = 11'h456; dat[0] = 64'h0000_0000_CAFE_F00D; deq_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (rdy !== 3'b000) begin n_err++; $display("FAIL stall_ready%0d: got %b want 000", k, rdy); end
            n_cmp++;
            if (deq_valid !== 1'b1 || deq_source !== 11'h123 || deq_data !== 64'hDEAD_BEEF_0000_0001) begin
                n_err++;
                $display("FAIL stall_hold%0d: got valid=%b src=%h data=%h want 1 123 deadbeef00000001",
                         k, deq_valid, deq_source, deq_data);
            end
            tick;
        end
        deq_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy !== 3'b001) begin n_err++; $display("FAIL stall_release: got %b want 001", rdy); end
        tick;
        v = 3'b000;
        #1;
        n_cmp++;
        if (deq_source !== 11'h456) begin n_err++; $display("FAIL stall_newsrc: got %h want 456", deq_source); end
        tick;
    endtask

    task automatic test_wrap;
        apply_reset;
        v = 3'b100; deq_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy !== 3'b100) begin n_err++; $display("FAIL wrap_first: got %b want 100", rdy); end
        tick;
        v = 3'b101;
        #1;
        n_cmp++;
        if (rdy !== 3'b001) begin n_err++; $display("FAIL wrap_grant: got %b want 001", rdy); end
        tick;
        v = 3'b000;
        tick;
    endtask

    task automatic test_reset_mid;
        apply_reset;
        v = 3'b010; deq_ready = 1'b0;
        tick;
        reset = 1'b1; v = 3'b000;
        tick;
        #1;
        n_cmp++;
        if (deq_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", deq_valid); end
        reset = 1'b0; v = 3'b111; deq_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy !== 3'b001) begin n_err++; $display("FAIL midreset_first: got %b want 001", rdy); end
        tick;
        v = 3'b000;
        tick;
    endtask

    task automatic test_random;
        int g;
        logic [2:0] exp_rdy;
        apply_reset;
        for (int c = 0; c < 3000; c++) begin
            v = 3'($urandom_range(7, 0));
            deq_ready = ($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0;
            for (int i = 0; i < 3; i++) begin
                op[i] = 3'($urandom); sz[i] = 2'($urandom);
                src[i] = 11'($urandom); dat[i] = {$urandom, $urandom};
            end
            #1;
            g = exp_grant(v, deq_ready);
            exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
            n_cmp++;
            if (rdy !== exp_rdy) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, rdy, exp_rdy); end
            n_cmp++;
            if (deq_valid !== m_full) begin n_err++; $display("FAIL rand_valid c%0d: got %b want %b", c, deq_valid, m_full); end
            if (m_full) begin
                n_cmp++;
                if ({deq_opcode, deq_size, deq_source, deq_data} !== {m_op, m_sz, m_src, m_dat}) begin
                    n_err++;
                    $display("FAIL rand_fields c%0d: got %h %h %h %h want %h %h %h %h", c,
                             deq_opcode, deq_size, deq_source, deq_data, m_op, m_sz, m_src, m_dat);
                end
            end
            model_step(v, deq_ready);
            tick;
        end
        v = 3'b000;
        tick;
    endtask

`ifdef D_ARB_GRANT_CNT_EN
    task automatic test_counters;
        apply_reset;
        v = 3'b001; deq_ready = 1'b1;
        repeat (70000) tick;
        v = 3'b000;
        #1;
        n_cmp++;
        if (cnt0 !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat0: got %h want ffff", cnt0); end
        n_cmp++;
        if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin n_err++; $display("FAIL cnt_others: got %h %h want 0 0", cnt1, cnt2); end
        tick;
    endtask
`endif

    initial begin
        reset = 1'b1; v = 3'b000; deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op[i] = 3'd0; sz[i] = 2'd0; src[i] = 11'd0; dat[i] = 64'd0;
        end
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_wrap;
        test_reset_mid;
        test_random;
`ifdef D_ARB_GRANT_CNT_EN
        test_counters;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d_resp_arbiter.md
D_RESP_ARBITER -- requirements
Module: d_resp_arbiter

Interface
REQ-001 SHALL have no parameters; 3 requesters and field widths are fixed.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports, for i in 0..2: io_in_<i>_valid  input  1  requester i holds a response.
REQ-005 SHALL have ports, for i in 0..2: io_in_<i>_ready  output  1  requester i response accepted this cycle.
REQ-006 SHALL have ports, for i in 0..2: io_in_<i>_bits_opcode/size/source/data  input  3/2/11/64  response fields.
REQ-007 SHALL have ports: io_deq_valid  output  1; io_deq_ready  input  1  downstream handshake.
REQ-008 SHALL have ports: io_deq_bits_opcode/param/size/source/sink/denied/data/corrupt  output  3/2/2/11/1/1/64/1  held response.
REQ-009 SHALL have ports, only with D_ARB_GRANT_CNT_EN defined, for i in 0..2: io_grant_count_<i>  output  16  grants to requester i.

Function
REQ-010 SHALL contain one holding entry (full flag + field registers); io_deq_valid = full; io_deq_bits_* driven directly from the entry.
REQ-011 SHALL define free = ~full | io_deq_ready; arbitration occurs only when free.
REQ-012 SHALL grant at most one requester per cycle; io_in_<i>_ready = 1 only for the granted requester, 0 for all others and whenever ~free.
REQ-013 SHALL use round-robin priority: search order starts at (last_grant+1) mod 3, wrapping 2->0.
REQ-014 SHALL update last_grant to the granted index on every grant; unchanged when no grant.
REQ-015 SHALL load opcode, size, source, data from the granted requester into the entry on grant; latency input-accept to io_deq_valid = 1 cycle.
REQ-016 SHALL drive io_deq_bits_param = 0, sink = 0, denied = 0, corrupt = 0 at all times.
REQ-017 SHALL update full: grant -> 1; else io_deq_ready & full -> 0; else hold.
REQ-018 SHALL, when full & io_deq_ready & a grant occur together, replace the entry in the same edge (no bubble, full stays 1); sustained throughput 1 response/cycle.
REQ-019 SHALL, when full & ~io_deq_ready, hold all entry fields stable and grant nothing.
REQ-020 SHALL not depend on io_in_<i>_ready for io_in_<i>_valid; valid may drop without handshake (no stickiness required of arbiter).
REQ-021 SHALL produce no X on io_in_<i>_ready or io_deq_valid after reset.

Reset
REQ-022 SHALL, on reset, clear full to 0 and set last_grant to 2 (requester 0 highest priority first).
REQ-023 SHALL, while reset is high, drive all io_in_<i>_ready = 0 and io_deq_valid = 0 from the next edge; no grant occurs that cycle.
REQ-024 SHALL discard any held entry on reset mid-operation; entry data registers are not reset.

Configuration
REQ-025 SHALL, with D_ARB_GRANT_CNT_EN defined, keep one 16-bit counter per requester: reset 0, +1 per grant, saturate at 0xFFFF, drive io_grant_count_<i>.
REQ-026 SHALL, without D_ARB_GRANT_CNT_EN, omit counters and io_grant_count_<i> ports; all other behaviour identical.

Verification
REQ-027 SHALL cover: reset, then only in_1 valid (source=0x005, data=0xA5) with deq_ready=1 -> in_1_ready=1 cycle 0; deq_valid=1 cycle 1 with source 0x005, data 0xA5, param/sink/denied/corrupt=0.
REQ-028 SHALL cover: all three valid continuously, deq_ready=1 -> grants 0,1,2,0,1,2; deq_valid stays 1 with no bubble.
REQ-029 SHALL cover: entry full, deq_ready=0 for 5 cycles, in_0 valid -> all readys 0, deq fields unchanged; ready=1 -> in_0 granted same cycle.
REQ-030 SHALL cover: last grant=2, in_0 and in_2 valid -> in_0 granted (wrap-around).
REQ-031 SHALL cover: reset asserted while full -> deq_valid=0 next cycle; after release first grant goes to in_0 when all valid.
REQ-032 SHALL cover, with D_ARB_GRANT_CNT_EN: 70000 grants to in_0 -> io_grant_count_0=0xFFFF, counts 1 and 2 = 0.
